// File: rtl/mc_main_ctrl.sv
// ============================================================================
// Module      : mc_main_ctrl
// Description : Multi-cycle MIPS main control FSM with memory-ready timeout.
//               Optional illegal-opcode trap enabled by MC_CTRL_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_main_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic [1:0] PCSource_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       MemtoReg_o,
    output logic       RegDst_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ALUOp_o,
    output logic       instr_done_o,
    output logic       mem_err_o,
    output logic       illegal_o
);

    localparam int                 c_CNT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] c_OP_R   = 6'b000000;
    localparam logic [5:0] c_OP_LW  = 6'b100011;
    localparam logic [5:0] c_OP_SW  = 6'b101011;
    localparam logic [5:0] c_OP_BEQ = 6'b000100;
    localparam logic [5:0] c_OP_ORI = 6'b001101;
    localparam logic [5:0] c_OP_J   = 6'b000010;

    localparam logic [3:0] c_IDLE   = 4'd0;
    localparam logic [3:0] c_FETCH  = 4'd1;
    localparam logic [3:0] c_DECODE = 4'd2;
    localparam logic [3:0] c_MEMADR = 4'd3;
    localparam logic [3:0] c_MEMRD  = 4'd4;
    localparam logic [3:0] c_MEMWB  = 4'd5;
    localparam logic [3:0] c_MEMWR  = 4'd6;
    localparam logic [3:0] c_REXEC  = 4'd7;
    localparam logic [3:0] c_RWB    = 4'd8;
    localparam logic [3:0] c_BEQ    = 4'd9;
    localparam logic [3:0] c_ORIEX  = 4'd10;
    localparam logic [3:0] c_ORIWB  = 4'd11;
    localparam logic [3:0] c_JUMP   = 4'd12;
`ifdef MC_CTRL_TRAP_EN
    localparam logic [3:0] c_TRAP   = 4'd13;
`endif

    logic [3:0]         state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               w_wait;
    logic               w_timeout;

    assign w_wait    = (state_q == c_FETCH) || (state_q == c_MEMRD) || (state_q == c_MEMWR);
    assign w_timeout = w_wait && !mem_ready_i && (cnt_q == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   state_d = c_FETCH;
            c_FETCH:  if (mem_ready_i) state_d = c_DECODE;
            c_DECODE: begin
                case (opcode_i)
                    c_OP_LW, c_OP_SW: state_d = c_MEMADR;
                    c_OP_R:           state_d = c_REXEC;
                    c_OP_BEQ:         state_d = c_BEQ;
                    c_OP_ORI:         state_d = c_ORIEX;
                    c_OP_J:           state_d = c_JUMP;
`ifdef MC_CTRL_TRAP_EN
                    default:          state_d = c_TRAP;
`else
                    default:          state_d = c_FETCH;
`endif
                endcase
            end
            c_MEMADR: state_d = (opcode_i == c_OP_LW) ? c_MEMRD : c_MEMWR;
            c_MEMRD: begin
                if (mem_ready_i)    state_d = c_MEMWB;
                else if (w_timeout) state_d = c_FETCH;
            end
            c_MEMWB:  state_d = c_FETCH;
            c_MEMWR:  if (mem_ready_i || w_timeout) state_d = c_FETCH;
            c_REXEC:  state_d = c_RWB;
            c_RWB:    state_d = c_FETCH;
            c_BEQ:    state_d = c_FETCH;
            c_ORIEX:  state_d = c_ORIWB;
            c_ORIWB:  state_d = c_FETCH;
            c_JUMP:   state_d = c_FETCH;
`ifdef MC_CTRL_TRAP_EN
            c_TRAP:   state_d = c_TRAP;
`endif
            default:  state_d = c_IDLE;
        endcase

        // A FETCH timeout re-enters FETCH without a state change, so it clears explicitly.
        if (w_timeout || (state_d != state_q))
            cnt_d = '0;
        else if (w_wait && !mem_ready_i)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;
    end

    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        PCSource_o    = 2'b00;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALUOp_o       = 2'b00;
        instr_done_o  = 1'b0;
        mem_err_o     = w_timeout;
        illegal_o     = 1'b0;
        case (state_q)
            c_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
            end
            c_DECODE: ALUSrcB_o = 2'b11;
            c_MEMADR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
            end
            c_MEMRD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            c_MEMWB: begin
                RegWrite_o   = 1'b1;
                MemtoReg_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            c_MEMWR: begin
                MemWrite_o   = 1'b1;
                IorD_o       = 1'b1;
                instr_done_o = mem_ready_i;
            end
            c_REXEC: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 2'b10;
            end
            c_RWB: begin
                RegWrite_o   = 1'b1;
                RegDst_o     = 1'b1;
                instr_done_o = 1'b1;
            end
            c_BEQ: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = 2'b01;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                instr_done_o  = 1'b1;
            end
            c_ORIEX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALUOp_o   = 2'b11;
            end
            c_ORIWB: begin
                RegWrite_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            c_JUMP: begin
                PCWrite_o    = 1'b1;
                PCSource_o   = 2'b10;
                instr_done_o = 1'b1;
            end
`ifdef MC_CTRL_TRAP_EN
            c_TRAP: illegal_o = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_main_ctrl.sv
// ============================================================================
// Module      : tb_mc_main_ctrl
// Description : Vector-table bench for mc_main_ctrl plus timeout/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_main_ctrl;

    // Expected-output packing: {PCW,PCWC,PCSrc[1:0],IorD,MRd,MWr,IRW,M2R,RDst,RW,SrcA,SrcB[1:0],ALUOp[1:0],done,err,ill}
    localparam logic [18:0] B_PCW    = 19'h1 << 18;
    localparam logic [18:0] B_PCWC   = 19'h1 << 17;
    localparam logic [18:0] B_PCS_J  = 19'h1 << 16;
    localparam logic [18:0] B_PCS_AO = 19'h1 << 15;
    localparam logic [18:0] B_IORD   = 19'h1 << 14;
    localparam logic [18:0] B_MRD    = 19'h1 << 13;
    localparam logic [18:0] B_MWR    = 19'h1 << 12;
    localparam logic [18:0] B_IRW    = 19'h1 << 11;
    localparam logic [18:0] B_M2R    = 19'h1 << 10;
    localparam logic [18:0] B_RDST   = 19'h1 << 9;
    localparam logic [18:0] B_RW     = 19'h1 << 8;
    localparam logic [18:0] B_SRCA   = 19'h1 << 7;
    localparam logic [18:0] B_SRCB_I = 19'h1 << 6;
    localparam logic [18:0] B_SRCB_4 = 19'h1 << 5;
    localparam logic [18:0] B_ALU_R  = 19'h1 << 4;
    localparam logic [18:0] B_ALU_S  = 19'h1 << 3;
    localparam logic [18:0] B_DONE   = 19'h1 << 2;
    localparam logic [18:0] B_ERR    = 19'h1 << 1;
    localparam logic [18:0] B_ILL    = 19'h1;

    localparam logic [18:0] E_ZERO    = 19'h0;
    localparam logic [18:0] E_FETCH_W = B_MRD | B_SRCB_4;
    localparam logic [18:0] E_FETCH_R = B_MRD | B_SRCB_4 | B_IRW | B_PCW;
    localparam logic [18:0] E_DECODE  = B_SRCB_I | B_SRCB_4;
    localparam logic [18:0] E_MEMADR  = B_SRCA | B_SRCB_I;
    localparam logic [18:0] E_MEMRD   = B_MRD | B_IORD;
    localparam logic [18:0] E_MEMWB   = B_RW | B_M2R | B_DONE;
    localparam logic [18:0] E_MEMWR_W = B_MWR | B_IORD;
    localparam logic [18:0] E_MEMWR_R = B_MWR | B_IORD | B_DONE;
    localparam logic [18:0] E_REXEC   = B_SRCA | B_ALU_R;
    localparam logic [18:0] E_RWB     = B_RW | B_RDST | B_DONE;
    localparam logic [18:0] E_BEQ     = B_SRCA | B_ALU_S | B_PCWC | B_PCS_AO | B_DONE;
    localparam logic [18:0] E_ORIEX   = B_SRCA | B_SRCB_I | B_ALU_R | B_ALU_S;
    localparam logic [18:0] E_ORIWB   = B_RW | B_DONE;
    localparam logic [18:0] E_JUMP    = B_PCW | B_PCS_J | B_DONE;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ORI = 6'b001101, OP_J = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        logic        rst_n;
        logic [5:0]  op;
        logic        rdy;
        logic [18:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode_i = 6'h0;
    logic       mem_ready_i = 1'b0;
    logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
    logic       MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, instr_done_o, mem_err_o, illegal_o;
    logic [1:0] PCSource_o, ALUSrcB_o, ALUOp_o;
    logic [18:0] act;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mc_main_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode_i     (opcode_i),
        .mem_ready_i  (mem_ready_i),
        .PCWrite_o    (PCWrite_o),
        .PCWriteCond_o(PCWriteCond_o),
        .PCSource_o   (PCSource_o),
        .IorD_o       (IorD_o),
        .MemRead_o    (MemRead_o),
        .MemWrite_o   (MemWrite_o),
        .IRWrite_o    (IRWrite_o),
        .MemtoReg_o   (MemtoReg_o),
        .RegDst_o     (RegDst_o),
        .RegWrite_o   (RegWrite_o),
        .ALUSrcA_o    (ALUSrcA_o),
        .ALUSrcB_o    (ALUSrcB_o),
        .ALUOp_o      (ALUOp_o),
        .instr_done_o (instr_done_o),
        .mem_err_o    (mem_err_o),
        .illegal_o    (illegal_o)
    );

    assign act = {PCWrite_o, PCWriteCond_o, PCSource_o, IorD_o, MemRead_o, MemWrite_o,
                  IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o,
                  ALUOp_o, instr_done_o, mem_err_o, illegal_o};

    task automatic add(input logic r, input logic [5:0] op, input logic rdy, input logic [18:0] e);
        vec_t v;
        v.rst_n = r; v.op = op; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [18:0] e);
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got %05h expected %05h", name, act, e);
        end
    endtask

    // Inputs change at the falling edge; outputs are checked 2 ns later, well before the rising edge.
    task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                        input logic [18:0] e, input string name);
        @(negedge clk);
        rst_n = r; opcode_i = op; mem_ready_i = rdy;
        #2;
        check(name, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        add(0, OP_R,   1, E_ZERO);
        add(1, OP_R,   1, E_ZERO);
        add(1, OP_R,   1, E_FETCH_R);
        add(1, OP_R,   1, E_DECODE);
        add(1, OP_R,   1, E_REXEC);
        add(1, OP_R,   1, E_RWB);
        add(1, OP_LW,  1, E_FETCH_R);
        add(1, OP_LW,  1, E_DECODE);
        add(1, OP_LW,  1, E_MEMADR);
        add(1, OP_LW,  0, E_MEMRD);
        add(1, OP_LW,  0, E_MEMRD);
        add(1, OP_LW,  0, E_MEMRD);
        add(1, OP_LW,  1, E_MEMRD);
        add(1, OP_LW,  1, E_MEMWB);
        add(1, OP_SW,  0, E_FETCH_W);
        add(1, OP_SW,  1, E_FETCH_R);
        add(1, OP_SW,  1, E_DECODE);
        add(1, OP_SW,  1, E_MEMADR);
        add(1, OP_SW,  0, E_MEMWR_W);
        add(1, OP_SW,  1, E_MEMWR_R);
        add(1, OP_BEQ, 1, E_FETCH_R);
        add(1, OP_BEQ, 1, E_DECODE);
        add(1, OP_BEQ, 1, E_BEQ);
        add(1, OP_ORI, 1, E_FETCH_R);
        add(1, OP_ORI, 1, E_DECODE);
        add(1, OP_ORI, 1, E_ORIEX);
        add(1, OP_ORI, 1, E_ORIWB);
        add(1, OP_J,   1, E_FETCH_R);
        add(1, OP_J,   1, E_DECODE);
        add(1, OP_J,   1, E_JUMP);
        add(1, OP_BAD, 1, E_FETCH_R);
        add(1, OP_BAD, 1, E_DECODE);
`ifdef MC_CTRL_TRAP_EN
        add(1, OP_R,   1, B_ILL);
        add(1, OP_LW,  1, B_ILL);
        add(1, OP_J,   0, B_ILL);
`else
        add(1, OP_R,   1, E_FETCH_R);
        add(1, OP_R,   1, E_DECODE);
`endif

        foreach (vecs[i])
            step(vecs[i].rst_n, vecs[i].op, vecs[i].rdy, vecs[i].exp, $sformatf("vec[%0d]", i));

        // FETCH timeout: error on 16th wait cycle, then a clean retry.
        step(0, OP_R, 0, E_ZERO, "rst");
        step(1, OP_R, 0, E_ZERO, "idle");
        for (int i = 0; i < 15; i++) step(1, OP_SW, 0, E_FETCH_W, $sformatf("fetch_wait%0d", i));
        step(1, OP_SW, 0, E_FETCH_W | B_ERR, "fetch_timeout");
        step(1, OP_SW, 0, E_FETCH_W, "fetch_retry");
        step(1, OP_SW, 1, E_FETCH_R, "fetch_ok");
        step(1, OP_SW, 1, E_DECODE, "sw_decode");
        step(1, OP_SW, 1, E_MEMADR, "sw_memadr");
        for (int i = 0; i < 15; i++) step(1, OP_SW, 0, E_MEMWR_W, $sformatf("memwr_wait%0d", i));
        step(1, OP_SW, 0, E_MEMWR_W | B_ERR, "memwr_timeout");
        step(1, OP_SW, 0, E_FETCH_W, "memwr_abort_fetch");

        // Ready on the would-be timeout cycle wins.
        step(1, OP_LW, 1, E_FETCH_R, "lw_fetch");
        step(1, OP_LW, 1, E_DECODE, "lw_decode");
        step(1, OP_LW, 1, E_MEMADR, "lw_memadr");
        for (int i = 0; i < 15; i++) step(1, OP_LW, 0, E_MEMRD, $sformatf("memrd_wait%0d", i));
        step(1, OP_LW, 1, E_MEMRD, "memrd_ready_last");
        step(1, OP_LW, 1, E_MEMWB, "memrd_wb");

        // Asynchronous reset mid-MEMRD.
        step(1, OP_LW, 1, E_FETCH_R, "lw2_fetch");
        step(1, OP_LW, 1, E_DECODE, "lw2_decode");
        step(1, OP_LW, 1, E_MEMADR, "lw2_memadr");
        step(1, OP_LW, 0, E_MEMRD, "lw2_memrd");
        #1 rst_n = 1'b0;
        #1 check("async_rst", E_ZERO);
        @(posedge clk);
        step(1, OP_LW, 1, E_ZERO, "post_rst_idle");
        step(1, OP_LW, 1, E_FETCH_R, "post_rst_fetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
